// File: rtl/mult_hilo_ctrl.sv
// Sequencing and HI/LO result stage around the 16x16 shift-add multiplier.
// Operands go to the multiplier as unsigned magnitudes; the sign is restored on capture.
module mult_hilo_ctrl #(
    parameter int MULT_LATENCY = 34
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Op_Start,
    input  logic        Op_Signed,
    input  logic [15:0] Op_A,
    input  logic [15:0] Op_B,
    input  logic        Mthi,
    input  logic        Mtlo,
    input  logic [31:0] Wdata,
    input  logic        Rd_Hi,
    input  logic        Rd_Lo,
    output logic [31:0] Rdata,
    output logic        Busy,
    output logic        Stall,
    output logic [15:0] Mul_Multiplicando,
    output logic [15:0] Mul_Multiplicador,
    output logic        Mul_St,
    output logic        Mul_Reset,
    input  logic [31:0] Mul_Produto
);

    localparam int CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    // -0x8000 wraps back to 0x8000, which is the correct unsigned magnitude.
    function automatic logic [15:0] magnitude16(input logic signed [15:0] x);
        logic signed [15:0] m;
        m = (x < 0) ? -x : x;
        return m;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] p, input logic neg);
        return neg ? (~p + 32'd1) : p;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             sgn_q, sgn_d;
    logic [15:0]      mca_q, mca_d;
    logic [15:0]      mcb_q, mcb_d;
    logic             st_q, st_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      res;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        sgn_d   = sgn_q;
        mca_d   = mca_q;
        mcb_d   = mcb_q;
        st_d    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res     = apply_sign(Mul_Produto, neg_q);
        case (state_q)
            S_IDLE: begin
                if (Mthi) hi_d = Wdata;
                if (Mtlo) lo_d = Wdata;
                if (Op_Start) begin
                    mca_d   = Op_Signed ? magnitude16(Op_A) : Op_A;
                    mcb_d   = Op_Signed ? magnitude16(Op_B) : Op_B;
                    // A zero operand never yields a negated (all-ones-carry) result.
                    neg_d   = Op_Signed & (Op_A[15] ^ Op_B[15]) & (|Op_A) & (|Op_B);
                    sgn_d   = Op_Signed;
                    st_d    = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                lo_d    = res;
                hi_d    = sgn_q ? {32{res[31]}} : 32'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            mca_q   <= 16'd0;
            mcb_q   <= 16'd0;
            st_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sgn_q   <= sgn_d;
            mca_q   <= mca_d;
            mcb_q   <= mcb_d;
            st_q    <= st_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy              = (state_q != S_IDLE);
    assign Stall             = Busy & (Op_Start | Mthi | Mtlo | Rd_Hi | Rd_Lo);
    assign Rdata             = Rd_Hi ? hi_q : (Rd_Lo ? lo_q : 32'd0);
    assign Mul_Multiplicando = mca_q;
    assign Mul_Multiplicador = mcb_q;
    assign Mul_St            = st_q;
    assign Mul_Reset         = Reset;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a behavioural fixed-latency multiplier
// and a queue of expected HI/LO results checked as each multiply completes.
module tb_mult_hilo_ctrl;

    localparam int LAT = 34;

    logic        Clk = 1'b0;
    logic        Reset, Op_Start, Op_Signed, Mthi, Mtlo, Rd_Hi, Rd_Lo;
    logic [15:0] Op_A, Op_B;
    logic [31:0] Wdata, Rdata, Mul_Produto;
    logic        Busy, Stall, Mul_St, Mul_Reset;
    logic [15:0] Mul_Multiplicando, Mul_Multiplicador;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    mult_hilo_ctrl #(.MULT_LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .Op_Start(Op_Start), .Op_Signed(Op_Signed),
        .Op_A(Op_A), .Op_B(Op_B), .Mthi(Mthi), .Mtlo(Mtlo), .Wdata(Wdata),
        .Rd_Hi(Rd_Hi), .Rd_Lo(Rd_Lo), .Rdata(Rdata), .Busy(Busy), .Stall(Stall),
        .Mul_Multiplicando(Mul_Multiplicando), .Mul_Multiplicador(Mul_Multiplicador),
        .Mul_St(Mul_St), .Mul_Reset(Mul_Reset), .Mul_Produto(Mul_Produto)
    );

    always #5 Clk = ~Clk;

    // Multiplier stand-in: garbage until exactly LAT cycles after the St edge.
    int          m_cnt;
    logic [15:0] m_a, m_b;
    always @(posedge Clk) begin
        if (Mul_Reset) begin
            m_cnt       <= 0;
            Mul_Produto <= 32'd0;
        end else if (Mul_St) begin
            m_a         <= Mul_Multiplicando;
            m_b         <= Mul_Multiplicador;
            m_cnt       <= LAT;
            Mul_Produto <= 32'hA5A5_5A5A;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) Mul_Produto <= {16'd0, m_a} * {16'd0, m_b};
        end
    end

    function automatic logic [63:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] ps;
        logic [31:0]        pu;
        if (s) begin
            ps = $signed(a) * $signed(b);
            return {{32{ps[31]}}, ps};
        end
        pu = {16'd0, a} * {16'd0, b};
        return {32'd0, pu};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_hi(input string tag, input logic [31:0] exp);
        Rd_Hi = 1'b1;
        #1;
        check(tag, Rdata, exp);
        Rd_Hi = 1'b0;
    endtask

    task automatic read_lo(input string tag, input logic [31:0] exp);
        Rd_Lo = 1'b1;
        #1;
        check(tag, Rdata, exp);
        Rd_Lo = 1'b0;
    endtask

    // Drive a request at a negedge; returns at the negedge inside LAUNCH.
    task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [15:0] ma;
        Op_A = a; Op_B = b; Op_Signed = s; Op_Start = 1'b1;
        sb_q.push_back(model(a, b, s));
        @(negedge Clk);
        Op_Start = 1'b0;
        ma = (s && a[15]) ? 16'(-a) : a;
        check({tag, "_busy_launch"}, 32'(Busy), 32'd1);
        check({tag, "_st_launch"}, 32'(Mul_St), 32'd1);
        check({tag, "_mcand"}, 32'(Mul_Multiplicando), 32'(ma));
    endtask

    // Wait for Busy to fall (bounded), then compare HI/LO against the scoreboard.
    task automatic finish_op(input string tag, input int seen);
        int          busy_n = seen;
        int          st_n = 1;
        logic [63:0] exp;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (!Busy) break;
            busy_n++;
            if (Mul_St) st_n++;
        end
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(LAT + 2));
        check({tag, "_st_pulses"}, 32'(st_n), 32'd1);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            exp = sb_q.pop_front();
            read_hi({tag, "_hi"}, exp[63:32]);
            Rd_Lo = 1'b1;
            #1;
            check({tag, "_lo"}, Rdata, exp[31:0]);
            check({tag, "_nostall"}, 32'(Stall), 32'd0);
            Rd_Lo = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stall_bad;
        logic [63:0] exp;
        Reset = 1'b1; Op_Start = 1'b0; Op_Signed = 1'b0; Op_A = 16'd0; Op_B = 16'd0;
        Mthi = 1'b0; Mtlo = 1'b0; Wdata = 32'd0; Rd_Hi = 1'b0; Rd_Lo = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_st", 32'(Mul_St), 32'd0);
        check("rst_mcand", 32'(Mul_Multiplicando), 32'd0);
        check("rst_mplier", 32'(Mul_Multiplicador), 32'd0);
        check("rst_mulreset", 32'(Mul_Reset), 32'd1);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_rdata_none", Rdata, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        read_hi("rst_hi", 32'd0);
        read_lo("rst_lo", 32'd0);

        // Unsigned max, then a signed op accepted in the first IDLE cycle.
        start_op("u_ffff", 16'hFFFF, 16'hFFFF, 1'b0);
        finish_op("u_ffff", 1);
        start_op("s_m3x5", 16'hFFFD, 16'h0005, 1'b1);
        finish_op("s_m3x5", 1);
        start_op("s_8000sq", 16'h8000, 16'h8000, 1'b1);
        finish_op("s_8000sq", 1);
        start_op("s_8000x0", 16'h8000, 16'h0000, 1'b1);
        finish_op("s_8000x0", 1);
        start_op("s_8000x1", 16'h8000, 16'h0001, 1'b1);
        finish_op("s_8000x1", 1);

        // Read hazard held through the whole multiply.
        start_op("haz", 16'h1234, 16'hFF00, 1'b1);
        Rd_Lo = 1'b1;
        #1;
        check("haz_stall_launch", 32'(Stall), 32'd1);
        stall_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (!Busy) break;
            if (!Stall) stall_bad++;
        end
        check("haz_stall_low_while_busy", 32'(stall_bad), 32'd0);
        check("haz_stall_after", 32'(Stall), 32'd0);
        exp = sb_q.pop_front();
        check("haz_rdata_after", Rdata, exp[31:0]);
        Rd_Lo = 1'b0;

        // Move to HI while idle.
        Mthi = 1'b1; Wdata = 32'h1234_5678;
        @(negedge Clk);
        Mthi = 1'b0;
        read_hi("mthi_idle", 32'h1234_5678);

        // Move to LO while busy is ignored.
        start_op("mtlo_busy", 16'h00FF, 16'h0100, 1'b0);
        Mtlo = 1'b1; Wdata = 32'hCAFE_BABE;
        #1;
        check("mtlo_busy_stall", 32'(Stall), 32'd1);
        @(negedge Clk);
        @(negedge Clk);
        Mtlo = 1'b0;
        finish_op("mtlo_busy", 3);

        // Move applied together with a start, then overwritten by the result.
        Mthi = 1'b1; Wdata = 32'h0BAD_F00D;
        start_op("mthi_start", 16'h7FFF, 16'h7FFF, 1'b1);
        Mthi = 1'b0;
        read_hi("mthi_start_applied", 32'h0BAD_F00D);
        finish_op("mthi_start", 1);

        // Reset five cycles into WAIT.
        start_op("rst_mid", 16'h1234, 16'h0100, 1'b0);
        for (int i = 0; i < 5; i++) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_st", 32'(Mul_St), 32'd0);
        read_hi("rst_mid_hi", 32'd0);
        read_lo("rst_mid_lo", 32'd0);
        void'(sb_q.pop_back());
        Reset = 1'b0;
        @(negedge Clk);
        start_op("u_7x6", 16'd7, 16'd6, 1'b0);
        finish_op("u_7x6", 1);
        read_lo("u_7x6_const", 32'h0000_002A);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
